// File: rtl/ddr_lives_display_pkg.sv
// Shared constants for the DDR lives/arrow display: game state encoding, symbol codes and
// active-high segment glyphs ({g..a}).
package ddr_lives_display_pkg;

  localparam int unsigned STATE_BITS = 2;
  localparam logic [STATE_BITS:0] STATE_IDLE = 3'd0;
  localparam logic [STATE_BITS:0] STATE_GAME = 3'd2;

  localparam int unsigned SYM_ZERO  = 0;
  localparam int unsigned SYM_ARROW = 10;
  localparam int unsigned SYM_BLANK = 21;

  localparam logic [6:0] SEG_ZERO             = 7'h3F;
  localparam logic [6:0] SEG_ONE              = 7'h06;
  localparam logic [6:0] SEG_TWO              = 7'h5B;
  localparam logic [6:0] SEG_THREE            = 7'h4F;
  localparam logic [6:0] SEG_FOUR             = 7'h66;
  localparam logic [6:0] SEG_FIVE             = 7'h6D;
  localparam logic [6:0] SEG_SIX              = 7'h7D;
  localparam logic [6:0] SEG_SEVEN            = 7'h07;
  localparam logic [6:0] SEG_EIGHT            = 7'h7F;
  localparam logic [6:0] SEG_NINE             = 7'h6F;
  localparam logic [6:0] SEG_ARROW_LEFT       = 7'h39;
  localparam logic [6:0] SEG_ARROW_DOWN       = 7'h1C;
  localparam logic [6:0] SEG_ARROW_UP         = 7'h23;
  localparam logic [6:0] SEG_ARROW_RIGHT      = 7'h0F;
  localparam logic [6:0] SEG_ARROW_LEFT_DOWN  = 7'h18;
  localparam logic [6:0] SEG_ARROW_LEFT_UP    = 7'h21;
  localparam logic [6:0] SEG_ARROW_RIGHT_DOWN = 7'h0C;
  localparam logic [6:0] SEG_ARROW_RIGHT_UP   = 7'h03;
  localparam logic [6:0] SEG_ARROW_LEFT_RIGHT = 7'h36;
  localparam logic [6:0] SEG_ARROW_UP_DOWN    = 7'h49;
  localparam logic [6:0] SEG_ARROW_ALL        = 7'h40;
  localparam logic [6:0] SEG_BLANK            = 7'h00;

endpackage

// File: rtl/ddr_lives_display_if.sv
// Game-side bundle for the lives display: FSM/arrow inputs and the board-facing outputs.
interface ddr_lives_display_if #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SYMBOL_BITS = 5,
  parameter int unsigned LIVES_BITS  = 3
);
  import ddr_lives_display_pkg::*;

  logic [STATE_BITS:0]               state;
  logic [NUM_DIGITS*SYMBOL_BITS-1:0] cur_arrows;
  logic                              miss;
  logic                              life_restore;
  logic [6:0]                        seg;
  logic [NUM_DIGITS-1:0]             an;
  logic [LIVES_BITS-1:0]             lives;
  logic                              game_over;

  modport master (
    output state, cur_arrows, miss, life_restore,
    input  seg, an, lives, game_over
  );

  modport slave (
    input  state, cur_arrows, miss, life_restore,
    output seg, an, lives, game_over
  );
endinterface

// File: rtl/ddr_lives_display_seg_decode.sv
// Combinational symbol -> seven-segment decoder; codes above SYM_BLANK render blank.
module ddr_lives_display_seg_decode
  import ddr_lives_display_pkg::*;
#(
  parameter int unsigned SYMBOL_BITS    = 5,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [SYMBOL_BITS-1:0] sym,
  output logic [6:0]             seg
);

  logic [6:0] raw;

  always_comb begin
    raw = SEG_BLANK;
    if (sym <= SYMBOL_BITS'(SYM_BLANK)) begin
      case (sym[4:0])
        5'd0:    raw = SEG_ZERO;
        5'd1:    raw = SEG_ONE;
        5'd2:    raw = SEG_TWO;
        5'd3:    raw = SEG_THREE;
        5'd4:    raw = SEG_FOUR;
        5'd5:    raw = SEG_FIVE;
        5'd6:    raw = SEG_SIX;
        5'd7:    raw = SEG_SEVEN;
        5'd8:    raw = SEG_EIGHT;
        5'd9:    raw = SEG_NINE;
        5'd10:   raw = SEG_ARROW_LEFT;
        5'd11:   raw = SEG_ARROW_DOWN;
        5'd12:   raw = SEG_ARROW_UP;
        5'd13:   raw = SEG_ARROW_RIGHT;
        5'd14:   raw = SEG_ARROW_LEFT_DOWN;
        5'd15:   raw = SEG_ARROW_LEFT_UP;
        5'd16:   raw = SEG_ARROW_RIGHT_DOWN;
        5'd17:   raw = SEG_ARROW_RIGHT_UP;
        5'd18:   raw = SEG_ARROW_LEFT_RIGHT;
        5'd19:   raw = SEG_ARROW_UP_DOWN;
        5'd20:   raw = SEG_ARROW_ALL;
        default: raw = SEG_BLANK;
      endcase
    end
  end

  assign seg = SEG_ACTIVE_LOW ? ~raw : raw;

endmodule

// File: rtl/ddr_lives_display.sv
// Multi-digit DDR display: latches lane arrows on each metronome beat while in game, tracks a
// saturating lives counter and scans the digits with one-hot anode drive.
module ddr_lives_display
  import ddr_lives_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SYMBOL_BITS    = 5,
  parameter int unsigned LIVES_BITS     = 3,
  parameter int unsigned LIVES_INIT     = 5,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input logic                clk,
  input logic                rst,
  input logic                metronome_clk,
  ddr_lives_display_if.slave bus
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DigW = NUM_DIGITS * SYMBOL_BITS;

  localparam logic [6:0]            SegOff   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AnOff    = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic [DigW-1:0]       AllBlank = {NUM_DIGITS{SYMBOL_BITS'(SYM_BLANK)}};

  logic [2:0]               met_q;
  logic                     beat, in_game;
  logic [DigW-1:0]          digit_q;
  logic [LIVES_BITS-1:0]    lives_q, lives_d;
  logic                     game_over_q;
  logic [CntW-1:0]          cnt_q;
  logic [IdxW-1:0]          idx_q;
  logic [SYMBOL_BITS-1:0]   cur_sym;
  logic [6:0]               seg_dec, seg_q;
  logic [NUM_DIGITS-1:0]    an_hot, an_q;

  // met_q[1:0] is the synchroniser, met_q[2] the edge-detect history.
  assign beat    = met_q[1] & ~met_q[2];
  assign in_game = (bus.state == STATE_GAME);

  always_comb begin
    lives_d = lives_q;
    if (in_game) begin
      if (bus.miss && !bus.life_restore && lives_q != '0) begin
        lives_d = lives_q - LIVES_BITS'(1);
      end else if (bus.life_restore && !bus.miss && lives_q < LIVES_BITS'(LIVES_INIT)) begin
        lives_d = lives_q + LIVES_BITS'(1);
      end
    end
  end

  always_comb begin
    cur_sym = SYMBOL_BITS'(SYM_BLANK);
    if (in_game) begin
      cur_sym = digit_q[idx_q*SYMBOL_BITS +: SYMBOL_BITS];
    end else if (idx_q == IdxW'(NUM_DIGITS - 1) && 32'(lives_q) <= 32'd9) begin
      cur_sym = SYMBOL_BITS'(lives_q);
    end
  end

  assign an_hot = NUM_DIGITS'(1) << idx_q;

  ddr_lives_display_seg_decode #(
    .SYMBOL_BITS    (SYMBOL_BITS),
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_decode (
    .sym (cur_sym),
    .seg (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      met_q       <= '0;
      digit_q     <= AllBlank;
      lives_q     <= LIVES_BITS'(LIVES_INIT);
      game_over_q <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      seg_q       <= SegOff;
      an_q        <= AnOff;
    end else begin
      met_q       <= {met_q[1:0], metronome_clk};
      lives_q     <= lives_d;
      game_over_q <= (lives_d == '0);
      if (in_game && beat) begin
        digit_q <= bus.cur_arrows;
      end
      if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
      // Anode and segments both follow idx_q so they switch together.
      seg_q <= seg_dec;
      an_q  <= SEG_ACTIVE_LOW ? ~an_hot : an_hot;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.lives     = lives_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_ddr_lives_display.sv
// Scoreboard bench for ddr_lives_display: stimulus queues expectations, a negedge monitor
// pops and compares them against the outputs.
module tb_ddr_lives_display;
  import ddr_lives_display_pkg::*;

  localparam int unsigned ND = 4;
  localparam int unsigned SB = 5;
  localparam int unsigned LB = 3;

  localparam logic [3:0] MSeg = 4'b1000;
  localparam logic [3:0] MAn  = 4'b0100;
  localparam logic [3:0] MLiv = 4'b0011;
  localparam logic [3:0] MAll = 4'b1111;

  logic clk = 1'b0;
  logic rst;
  logic metronome_clk;

  ddr_lives_display_if #(.NUM_DIGITS(ND), .SYMBOL_BITS(SB), .LIVES_BITS(LB)) bus ();

  ddr_lives_display #(
    .NUM_DIGITS     (ND),
    .SYMBOL_BITS    (SB),
    .LIVES_BITS     (LB),
    .LIVES_INIT     (5),
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .metronome_clk (metronome_clk),
    .bus           (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] mask;   // {seg, an, lives, game_over}
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] lives;
    logic       go;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;
  exp_t  mon_e;
  string mon_n;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      if (mon_e.mask[3]) begin
        checks++;
        if (bus.seg !== mon_e.seg) begin
          failures++;
          $display("FAIL %s seg got %h want %h", mon_n, bus.seg, mon_e.seg);
        end
      end
      if (mon_e.mask[2]) begin
        checks++;
        if (bus.an !== mon_e.an) begin
          failures++;
          $display("FAIL %s an got %h want %h", mon_n, bus.an, mon_e.an);
        end
      end
      if (mon_e.mask[1]) begin
        checks++;
        if (bus.lives !== mon_e.lives) begin
          failures++;
          $display("FAIL %s lives got %0d want %0d", mon_n, bus.lives, mon_e.lives);
        end
      end
      if (mon_e.mask[0]) begin
        checks++;
        if (bus.game_over !== mon_e.go) begin
          failures++;
          $display("FAIL %s game_over got %b want %b", mon_n, bus.game_over, mon_e.go);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input logic [3:0] mask, input logic [6:0] seg,
                      input logic [3:0] an, input logic [2:0] lives, input logic go);
    exp_t e;
    e.mask = mask;
    e.seg  = seg;
    e.an   = an;
    e.lives = lives;
    e.go   = go;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Advance until the given digit is lit; a missed bound counts as a failure.
  task automatic wait_digit(input int d);
    logic [3:0] want;
    bit found;
    want  = ~(4'b0001 << d);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus.an === want) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL wait_digit%0d an got %h want %h", d, bus.an, want);
    end
  endtask

  task automatic step(input string n, input logic m, input logic r, input logic [2:0] lv,
                      input logic go);
    bus.miss         = m;
    bus.life_restore = r;
    tick();
    bus.miss         = 1'b0;
    bus.life_restore = 1'b0;
    push(n, MLiv, 7'h00, 4'h0, lv, go);
  endtask

  logic [6:0] arrow_seg [4];
  logic [6:0] want_seg;

  initial begin
    // Active-low glyphs for digits 0..3 holding symbols 13,12,11,10.
    arrow_seg[0] = 7'h70;
    arrow_seg[1] = 7'h5C;
    arrow_seg[2] = 7'h63;
    arrow_seg[3] = 7'h46;

    rst              = 1'b1;
    metronome_clk    = 1'b0;
    bus.state        = STATE_IDLE;
    bus.cur_arrows   = '0;
    bus.miss         = 1'b0;
    bus.life_restore = 1'b0;
    tick();
    tick();
    push("reset", MAll, 7'h7F, 4'hF, 3'd5, 1'b0);
    rst = 1'b0;

    // Out of game: digits 0..2 blank, digit 3 shows lives=5 (active-low 7'h12).
    for (int k = 1; k <= 16; k++) begin
      int d;
      tick();
      d = (k - 1) / 4;
      want_seg = (d == 3) ? 7'h12 : 7'h7F;
      push("scan", MSeg | MAn, want_seg, ~(4'b0001 << d), 3'd0, 1'b0);
    end

    bus.state      = STATE_GAME;
    bus.cur_arrows = {5'd10, 5'd11, 5'd12, 5'd13};
    metronome_clk  = 1'b1;
    repeat (6) tick();
    metronome_clk  = 1'b0;
    for (int d = 0; d < 4; d++) begin
      wait_digit(d);
      push("arrow_latch", MSeg, arrow_seg[d], 4'h0, 3'd0, 1'b0);
    end

    bus.cur_arrows = {5'd0, 5'd1, 5'd2, 5'd3};
    repeat (20) tick();
    for (int d = 0; d < 4; d++) begin
      wait_digit(d);
      push("arrow_hold", MSeg, arrow_seg[d], 4'h0, 3'd0, 1'b0);
    end

    step("miss1", 1'b1, 1'b0, 3'd4, 1'b0);
    step("miss2", 1'b1, 1'b0, 3'd3, 1'b0);
    step("miss3", 1'b1, 1'b0, 3'd2, 1'b0);
    step("miss4", 1'b1, 1'b0, 3'd1, 1'b0);
    step("miss5", 1'b1, 1'b0, 3'd0, 1'b1);
    step("miss6_sat", 1'b1, 1'b0, 3'd0, 1'b1);
    step("restore1", 1'b0, 1'b1, 3'd1, 1'b0);
    step("restore2", 1'b0, 1'b1, 3'd2, 1'b0);
    step("restore3", 1'b0, 1'b1, 3'd3, 1'b0);
    step("miss_and_restore", 1'b1, 1'b1, 3'd3, 1'b0);
    step("restore4", 1'b0, 1'b1, 3'd4, 1'b0);
    step("restore5", 1'b0, 1'b1, 3'd5, 1'b0);
    step("restore_cap", 1'b0, 1'b1, 3'd5, 1'b0);
    bus.state = STATE_IDLE;
    step("miss_idle", 1'b1, 1'b0, 3'd5, 1'b0);

    bus.state = STATE_GAME;
    step("miss_to4", 1'b1, 1'b0, 3'd4, 1'b0);
    step("miss_to3", 1'b1, 1'b0, 3'd3, 1'b0);
    bus.state = STATE_IDLE;
    wait_digit(3);
    push("lives_three", MSeg, 7'h30, 4'h0, 3'd0, 1'b0);
    wait_digit(0);
    push("idle_blank", MSeg, 7'h7F, 4'h0, 3'd0, 1'b0);

    bus.state = STATE_GAME;
    step("miss_to2", 1'b1, 1'b0, 3'd2, 1'b0);
    step("miss_to1", 1'b1, 1'b0, 3'd1, 1'b0);
    wait_digit(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push("rst_mid", MAll, 7'h7F, 4'hF, 3'd5, 1'b0);
    tick();
    push("rst_idx0", MAn, 7'h00, 4'hE, 3'd0, 1'b0);
    for (int d = 1; d < 4; d++) begin
      wait_digit(d);
      push("rst_blank", MSeg, 7'h7F, 4'h0, 3'd0, 1'b0);
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
